// File: rtl/rx_cmd_parser.sv
// Command framer between the RX FIFO and the action logic: pops an opcode plus an
// optional 16-bit MSB-first argument and presents one whole command per valid/ready handshake.
module rx_cmd_parser #(
  parameter int unsigned TIMEOUT_CYCLES      = 1000000,
  parameter logic [7:0]  CMD_RESET           = 8'h01,
  parameter logic [7:0]  CMD_TOGGLE_MCP      = 8'h02,
  parameter logic [7:0]  CMD_TOGGLE_READ_CCD = 8'h03,
  parameter logic [7:0]  CMD_OPEN_SHUTTER    = 8'h04,
  parameter logic [7:0]  CMD_CLOSE_SHUTTER   = 8'h05,
  parameter logic [7:0]  CMD_SET_REGISTER    = 8'h06,
  parameter logic [7:0]  CMD_RW_ADCONF       = 8'h07
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rempty,
  input  logic [7:0]  rx_rdata,
  output logic        rx_rinc,
  input  logic        ft_busy,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic [15:0] cmd_arg,
  input  logic        cmd_ready,
  output logic        err_unknown,
  output logic        err_timeout,
  output logic [7:0]  err_count,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  // Handshake: a command transfers on a rising edge where cmd_valid=1 and cmd_ready=1;
  // cmd_valid, cmd_code and cmd_arg hold steady until then and cmd_ready is ignored otherwise.

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GUARD_C  = 3'd1,
    WAIT_MSB = 3'd2,
    GUARD_M  = 3'd3,
    WAIT_LSB = 3'd4,
    HOLD     = 3'd5
  } state_e;

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    op_q, op_d;
  logic [7:0]    msb_q, msb_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic [7:0]    cmd_code_q, cmd_code_d;
  logic [15:0]   cmd_arg_q, cmd_arg_d;
  logic          err_unknown_q, err_unknown_d;
  logic          err_timeout_q, err_timeout_d;
  logic [7:0]    err_count_q, err_count_d;

  logic pop;
  logic in_frame;
  logic is_noarg;
  logic is_arg;

  always_comb begin
    // Gating with rst_n keeps queued bytes in the FIFO while reset is held.
    pop = rst_n && ((state_q == IDLE) || (state_q == WAIT_MSB) || (state_q == WAIT_LSB))
          && !rx_rempty && !ft_busy && !cmd_valid_q;
    in_frame = (state_q == GUARD_C) || (state_q == WAIT_MSB) ||
               (state_q == GUARD_M) || (state_q == WAIT_LSB);
    is_noarg = (rx_rdata == CMD_RESET) || (rx_rdata == CMD_TOGGLE_MCP) ||
               (rx_rdata == CMD_TOGGLE_READ_CCD) || (rx_rdata == CMD_OPEN_SHUTTER) ||
               (rx_rdata == CMD_CLOSE_SHUTTER);
    is_arg   = (rx_rdata == CMD_SET_REGISTER) || (rx_rdata == CMD_RW_ADCONF);

    state_d       = state_q;
    op_d          = op_q;
    msb_d         = msb_q;
    cmd_valid_d   = cmd_valid_q;
    cmd_code_d    = cmd_code_q;
    cmd_arg_d     = cmd_arg_q;
    err_unknown_d = 1'b0;
    err_timeout_d = 1'b0;
    err_count_d   = err_count_q;
    timer_d       = in_frame ? timer_q + TW'(1) : '0;
    if (pop) timer_d = '0;

    case (state_q)
      IDLE: begin
        if (pop) begin
          if (is_noarg) begin
            cmd_code_d  = rx_rdata;
            cmd_arg_d   = 16'h0000;
            cmd_valid_d = 1'b1;
            state_d     = HOLD;
          end else if (is_arg) begin
            op_d    = rx_rdata;
            state_d = GUARD_C;
          end else begin
            err_unknown_d = 1'b1;
          end
        end
      end
      GUARD_C: state_d = WAIT_MSB;
      WAIT_MSB: begin
        if (pop) begin
          msb_d   = rx_rdata;
          state_d = GUARD_M;
        end
      end
      GUARD_M: state_d = WAIT_LSB;
      WAIT_LSB: begin
        if (pop) begin
          cmd_arg_d   = {msb_q, rx_rdata};
          cmd_code_d  = op_q;
          cmd_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A pop in the final allowed cycle wins over the timeout.
    if (in_frame && !pop && (timer_q == TMO_LAST)) begin
      err_timeout_d = 1'b1;
      state_d       = IDLE;
      timer_d       = '0;
      op_d          = 8'h00;
      msb_d         = 8'h00;
    end

    if ((err_unknown_d || err_timeout_d) && (err_count_q != 8'hFF))
      err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      op_q          <= 8'h00;
      msb_q         <= 8'h00;
      cmd_valid_q   <= 1'b0;
      cmd_code_q    <= 8'h00;
      cmd_arg_q     <= 16'h0000;
      err_unknown_q <= 1'b0;
      err_timeout_q <= 1'b0;
      err_count_q   <= 8'h00;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      op_q          <= op_d;
      msb_q         <= msb_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_code_q    <= cmd_code_d;
      cmd_arg_q     <= cmd_arg_d;
      err_unknown_q <= err_unknown_d;
      err_timeout_q <= err_timeout_d;
      err_count_q   <= err_count_d;
    end
  end

  assign rx_rinc     = pop;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_code    = cmd_code_q;
  assign cmd_arg     = cmd_arg_q;
  assign err_unknown = err_unknown_q;
  assign err_timeout = err_timeout_q;
  assign err_count   = err_count_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_rx_cmd_parser.sv
// Bench for rx_cmd_parser: FIFO model and input driver, frame-level expectation model,
// output monitor with scoreboard queue, directed timing cases and a randomized stream.
module tb_rx_cmd_parser;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_rempty = 1'b1;
  logic [7:0]  rx_rdata = 8'h00;
  logic        ft_busy = 1'b0;
  logic        cmd_ready = 1'b0;
  logic        rx_rinc, cmd_valid, err_unknown, err_timeout, busy;
  logic [7:0]  cmd_code, err_count;
  logic [15:0] cmd_arg;
  logic [2:0]  dbg_state;

  rx_cmd_parser #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_rempty(rx_rempty), .rx_rdata(rx_rdata),
    .rx_rinc(rx_rinc), .ft_busy(ft_busy), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .cmd_arg(cmd_arg), .cmd_ready(cmd_ready), .err_unknown(err_unknown),
    .err_timeout(err_timeout), .err_count(err_count), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial forever #5 clk = ~clk;

  // ---------------- shared state ----------------
  logic [7:0]  fifo_q[$];
  logic [25:0] exp_q[$];      // {kind, code, arg}: kind 0=command, 1=unknown, 2=timeout
  int          pop_log[$];
  int          vstart_q[$];
  int          vlen_q[$];
  int          cyc = 0;
  int          to_cyc = -1;
  int          n_checks = 0;
  int          n_errors = 0;
  int          err_model = 0;
  bit          rand_stall = 0;
  bit          force_busy = 0;
  int          ready_mode = 1;  // 0 held low, 1 tied high, 2 random

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s actual=bound_expired expected=event", name);
  endtask

  // ---------------- reference model (frame level) ----------------
  task automatic exp_err(input logic [1:0] kind);
    exp_q.push_back({kind, 24'h0});
    if (err_model < 255) err_model++;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [15:0] arg);
    if (op >= 8'h01 && op <= 8'h05) begin
      fifo_q.push_back(op);
      exp_q.push_back({2'd0, op, 16'h0000});
    end else if (op == 8'h06 || op == 8'h07) begin
      fifo_q.push_back(op);
      fifo_q.push_back(arg[15:8]);
      fifo_q.push_back(arg[7:0]);
      exp_q.push_back({2'd0, op, arg});
    end else begin
      fifo_q.push_back(op);
      exp_err(2'd1);
    end
  endtask

  // ---------------- FIFO model and input driver ----------------
  initial begin
    bit pop_now;
    int stall_run;
    int s;
    stall_run = 0;
    forever begin
      @(negedge clk);
      pop_now = rx_rinc;
      @(posedge clk);
      #1;
      cyc++;
      if (pop_now) begin
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        pop_log.push_back(cyc);
      end
      s = -1;
      if (rand_stall && stall_run < 2 && $urandom_range(0, 3) == 0) begin
        stall_run++;
        s = int'($urandom_range(0, 1));
      end else begin
        stall_run = 0;
      end
      ft_busy   = force_busy || (s == 0);
      rx_rempty = (fifo_q.size() == 0) || (s == 1);
      rx_rdata  = (fifo_q.size() > 0) ? fifo_q[0] : 8'($urandom);
      cmd_ready = (ready_mode == 0) ? 1'b0 : (ready_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit vprev = 0;
  int vlen = 0;

  task automatic sb_compare(input string name, input logic [25:0] act);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s actual=%h expected=none", name, act);
    end else begin
      check(name, 32'(act), 32'(exp_q.pop_front()));
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (cmd_valid) begin
        if (!vprev) vstart_q.push_back(cyc);
        vlen++;
      end else if (vprev) begin
        vlen_q.push_back(vlen);
        vlen = 0;
      end
      vprev = cmd_valid;
      if (cmd_valid && cmd_ready) sb_compare("cmd", {2'd0, cmd_code, cmd_arg});
      if (err_unknown) sb_compare("err_unknown", {2'd1, 24'h0});
      if (err_timeout) begin
        to_cyc = cyc;
        sb_compare("err_timeout", {2'd2, 24'h0});
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic clear_logs();
    pop_log.delete();
    vstart_q.delete();
    vlen_q.delete();
    to_cyc = -1;
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0 || busy) && n < max) begin
      @(negedge clk);
      n++;
    end
    if (n >= max) fail_now("drain");
    @(negedge clk);
  endtask

  function automatic int qget(input int q[$], input int idx);
    return (idx < q.size()) ? q[idx] : -1000;
  endfunction

  // ---------------- directed and random stimulus ----------------
  initial begin
    bit stable, saw;
    int n;

    repeat (3) @(negedge clk);
    check("rst_rinc", 32'(rx_rinc), 0);
    check("rst_valid", 32'(cmd_valid), 0);
    check("rst_code", 32'(cmd_code), 0);
    check("rst_arg", 32'(cmd_arg), 0);
    check("rst_errs", 32'({err_unknown, err_timeout}), 0);
    check("rst_count", 32'(err_count), 0);
    check("rst_busy", 32'(busy), 0);
    @(posedge clk); #3 rst_n = 1'b1;

    // single no-argument command, consumer always ready
    @(negedge clk);
    clear_logs();
    send_frame(8'h04, 16'h0);
    wait_drain(50);
    check("t1_pops", 32'(pop_log.size()), 1);
    check("t1_latency", 32'(qget(vstart_q, 0) - qget(pop_log, 0)), 0);
    check("t1_vlen", 32'(qget(vlen_q, 0)), 1);

    // argument command: pops two cycles apart, valid right after the LSB pop edge
    clear_logs();
    send_frame(8'h06, 16'h02A5);
    wait_drain(50);
    check("t2_pops", 32'(pop_log.size()), 3);
    check("t2_gap1", 32'(qget(pop_log, 1) - qget(pop_log, 0)), 2);
    check("t2_gap2", 32'(qget(pop_log, 2) - qget(pop_log, 1)), 2);
    check("t2_latency", 32'(qget(vstart_q, 0) - qget(pop_log, 0)), 4);

    // consumer stalls: command held stable, no pops meanwhile
    ready_mode = 0;
    clear_logs();
    send_frame(8'h07, 16'h1234);
    send_frame(8'h05, 16'h0);
    n = 0;
    while (!cmd_valid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) fail_now("t3_valid_wait");
    stable = 1;
    repeat (10) begin
      @(negedge clk);
      if (!cmd_valid || cmd_arg != 16'h1234 || cmd_code != 8'h07 || rx_rinc) stable = 0;
    end
    check("t3_hold_stable", 32'(stable), 1);
    ready_mode = 1;
    n = 0;
    while (!cmd_ready && n < 10) begin @(negedge clk); n++; end
    @(negedge clk);
    check("t3_release", 32'(cmd_valid), 0);
    wait_drain(50);
    check("t3_pops", 32'(pop_log.size()), 4);

    // unknown opcode discarded, next command parsed
    clear_logs();
    send_frame(8'hEE, 16'h0);
    send_frame(8'h03, 16'h0);
    wait_drain(50);
    check("t4_count", 32'(err_count), 32'(err_model));

    // abandoned argument frame
    clear_logs();
    fifo_q.push_back(8'h06);
    fifo_q.push_back(8'h01);
    exp_err(2'd2);
    wait_drain(100);
    check("t5_to_delay", 32'(to_cyc - qget(pop_log, 1)), 16);
    check("t5_busy", 32'(busy), 0);
    check("t5_count", 32'(err_count), 32'(err_model));
    send_frame(8'h05, 16'h0);
    wait_drain(50);

    // ft_busy blocks all pops
    force_busy = 1;
    send_frame(8'h01, 16'h0);
    saw = 0;
    repeat (20) begin @(negedge clk); if (rx_rinc) saw = 1; end
    check("t6_no_pop_busy", 32'(saw), 0);
    check("t6_fifo_kept", 32'(fifo_q.size()), 1);
    force_busy = 0;
    wait_drain(50);

    // reset in the middle of an argument frame
    clear_logs();
    fifo_q.push_back(8'h07);
    fifo_q.push_back(8'h12);
    n = 0;
    while (pop_log.size() < 2 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) fail_now("t7_pop_wait");
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("t7_rst_outputs", 32'({rx_rinc, cmd_valid, cmd_code, cmd_arg, err_unknown, err_timeout}), 0);
    check("t7_rst_count_busy", 32'({err_count, busy}), 0);
    err_model = 0;
    send_frame(8'h03, 16'h0);
    saw = 0;
    repeat (4) begin @(negedge clk); if (rx_rinc) saw = 1; end
    check("t7_no_pop_in_reset", 32'(saw), 0);
    @(posedge clk); #3 rst_n = 1'b1;
    wait_drain(50);

    // error counter saturation
    for (int i = 0; i < 260; i++) send_frame(8'($urandom_range(8, 255)), 16'h0);
    wait_drain(2000);
    check("sat_count", 32'(err_count), 255);

    // randomized stream with stalls and a random consumer
    rand_stall = 1;
    ready_mode = 2;
    for (int i = 0; i < 150; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 4) send_frame(8'($urandom_range(1, 5)), 16'h0);
      else if (r < 8) send_frame(8'($urandom_range(6, 7)), 16'($urandom));
      else if (r == 8) send_frame(8'h00, 16'h0);
      else send_frame(8'($urandom_range(8, 255)), 16'h0);
    end
    wait_drain(6000);
    check("rand_count", 32'(err_count), 32'(err_model));
    check("rand_exp_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
